// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and buffered load results into one registered
// register-file write per cycle, and tracks registers with loads in flight.
// Latency: ALU 1 cycle to reg_write; load 2 cycles from accept to reg_write (empty FIFO).
// Backpressure: ALU has none and always wins; loads see ld_ready low only when the FIFO is full.
// Optional feature macro: WB_BYPASS_EN (forward the presented write to the read ports).
module reg_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  read_index1,
  input  logic [4:0]  read_index2,
  output logic        stall,
  output logic        reg_write,
  output logic [4:0]  write_index,
  output logic [31:0] write_data,
  output logic        fwd_valid1,
  output logic        fwd_valid2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH;

  // Load buffer storage and pointers
  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic fifo_full, fifo_empty, push, pop;

  // Selection result for this cycle
  logic        sel_vld;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  // Registered write port; from_fifo_q remembers which path the presented write came from
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_index_q, write_index_d;
  logic [31:0] write_data_q, write_data_d;
  logic        from_fifo_q, from_fifo_d;

  // Busy scoreboard, bit 0 is never set
  logic [31:0] busy_q, busy_d;
  logic [31:0] set_mask, clr_mask;

  logic stall1, stall2;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  // ld_ready depends only on the registered count, never on a same-cycle pop
  assign ld_ready   = !fifo_full;
  assign push       = ld_valid && !fifo_full;
  // count_q is registered, so an entry pushed into an empty FIFO is first poppable next cycle
  assign pop        = !alu_valid && !fifo_empty;

  // Pick ALU result first, else FIFO head, and compute FIFO pointer/count updates
  always_comb begin
    sel_vld  = alu_valid || pop;
    sel_rd   = alu_valid ? alu_rd   : fifo_rd_q[rd_ptr_q];
    sel_data = alu_valid ? alu_data : fifo_data_q[rd_ptr_q];

    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Next-state of the write port: x0 targets are consumed without a write; idle cycles hold address/data
  always_comb begin
    reg_write_d   = sel_vld && (sel_rd != 5'd0);
    write_index_d = sel_vld ? sel_rd   : write_index_q;
    write_data_d  = sel_vld ? sel_data : write_data_q;
    from_fifo_d   = pop;
  end

  // Busy update: FIFO-path writes clear, issues set, set wins on collision
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (issue_valid) begin
      set_mask = 32'd1 << issue_rd;
    end
    if (reg_write_q && from_fifo_q) begin
      clr_mask = 32'd1 << write_index_q;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  // FIFO storage writes; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= ld_rd;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      reg_write_q   <= 1'b0;
      write_index_q <= 5'd0;
      write_data_q  <= 32'd0;
      from_fifo_q   <= 1'b0;
      busy_q        <= 32'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      reg_write_q   <= reg_write_d;
      write_index_q <= write_index_d;
      write_data_q  <= write_data_d;
      from_fifo_q   <= from_fifo_d;
      busy_q        <= busy_d;
    end
  end

  assign reg_write   = reg_write_q;
  assign write_index = write_index_q;
  assign write_data  = write_data_q;

`ifdef WB_BYPASS_EN
  // Stall on busy sources, except a source whose pending load is being written right now (it is forwarded)
  always_comb begin
    stall1 = busy_q[read_index1] && (read_index1 != 5'd0) &&
             !(reg_write_q && from_fifo_q && (write_index_q == read_index1));
    stall2 = busy_q[read_index2] && (read_index2 != 5'd0) &&
             !(reg_write_q && from_fifo_q && (write_index_q == read_index2));
  end

  assign fwd_valid1 = reg_write_q && (write_index_q == read_index1) && (read_index1 != 5'd0);
  assign fwd_valid2 = reg_write_q && (write_index_q == read_index2) && (read_index2 != 5'd0);
  assign fwd_data1  = write_data_q;
  assign fwd_data2  = write_data_q;
`else
  // Without forwarding, a source being written this cycle is not readable yet, so it stalls too
  always_comb begin
    stall1 = (read_index1 != 5'd0) &&
             (busy_q[read_index1] || (reg_write_q && (write_index_q == read_index1)));
    stall2 = (read_index2 != 5'd0) &&
             (busy_q[read_index2] || (reg_write_q && (write_index_q == read_index2)));
  end

  assign fwd_valid1 = 1'b0;
  assign fwd_valid2 = 1'b0;
  assign fwd_data1  = 32'd0;
  assign fwd_data2  = 32'd0;
`endif

  assign stall = stall1 || stall2;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vectors, expected register-file writes queued in order,
// a negedge monitor pops and compares every write the DUT presents.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        nRST;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  read_index1;
  logic [4:0]  read_index2;
  logic        stall;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic        fwd_valid1;
  logic        fwd_valid2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;

  always #5 clk = ~clk;

  reg_writeback #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .nRST(nRST),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .read_index1(read_index1), .read_index2(read_index2), .stall(stall),
    .reg_write(reg_write), .write_index(write_index), .write_data(write_data),
    .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic exp_push(input logic [4:0] i, input logic [31:0] d);
    wr_t e;
    e.idx = i;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  // Drive point: 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented write must match the oldest expected write
  always @(negedge clk) begin
    if (nRST === 1'b1 && reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got idx %0d data %h want no write", write_index, write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_index", {27'd0, write_index}, {27'd0, mon_e.idx});
        chk("wr_data", write_data, mon_e.dat);
      end
    end
  end

  bit [5:0] rdy_exp = 6'b100011;  // expected ld_ready per cycle of the priority test (bit c)
  int       li;

  initial begin
    nRST = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    read_index1 = 5'd0; read_index2 = 5'd0;

    // Reset values
    @(negedge clk);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_write_index", {27'd0, write_index}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fwd_valid1", {31'd0, fwd_valid1}, 32'd0);
    chk("rst_fwd_data2", fwd_data2, 32'd0);
    tick();
    nRST = 1'b1;
    tick();
    tick();

    // ALU path: 1-cycle latency, then hold data on idle
    exp_push(5'd5, 32'h12345678);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h12345678;
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("alu_latency", {31'd0, reg_write}, 32'd1);
    tick();
    @(negedge clk);
    chk("idle_no_write", {31'd0, reg_write}, 32'd0);
    chk("idle_hold_data", write_data, 32'h12345678);
    tick();

    // x0 drop on both paths
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0BAD0BAD;
    @(negedge clk);
    chk("x0_alu_no_write", {31'd0, reg_write}, 32'd0);
    tick();
    ld_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("x0_ld_no_write", {31'd0, reg_write}, 32'd0);
    tick();
    tick();

    // Priority and full: ALU held 4 cycles, 3 loads offered; a leftover x0 entry would fill the FIFO early
    for (int i = 0; i < 4; i++) exp_push(5'(10 + i), 32'hA0000000 + 32'(i));
    for (int i = 0; i < 3; i++) exp_push(5'(20 + i), 32'hB0000000 + 32'(i));
    li = 0;
    for (int c = 0; c < 7; c++) begin
      alu_valid = (c < 4);
      alu_rd    = 5'(10 + c);
      alu_data  = 32'hA0000000 + 32'(c);
      ld_valid  = (li < 3);
      ld_rd     = 5'(20 + li);
      ld_data   = 32'hB0000000 + 32'(li);
      @(negedge clk);
      if (c < 6) begin
        chk($sformatf("ld_ready_c%0d", c), {31'd0, ld_ready}, {31'd0, rdy_exp[c]});
        if (ld_valid && rdy_exp[c]) li++;
      end
      tick();
    end
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    repeat (4) tick();

    // Scoreboard: load to x7
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    read_index1 = 5'd7;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hCAFEF00D;
    exp_push(5'd7, 32'hCAFEF00D);
    @(negedge clk);
    chk("sb_stall_accept", {31'd0, stall}, 32'd1);
    tick();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("sb_stall_pop", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("sb_fwd_valid1", {31'd0, fwd_valid1}, 32'd1);
    chk("sb_fwd_data1", fwd_data1, 32'hCAFEF00D);
    chk("sb_stall_write", {31'd0, stall}, 32'd0);
`else
    chk("sb_stall_write", {31'd0, stall}, 32'd1);
    chk("sb_fwd_valid1", {31'd0, fwd_valid1}, 32'd0);
`endif
    tick();
    @(negedge clk);
    chk("sb_stall_after", {31'd0, stall}, 32'd0);
    tick();
    read_index1 = 5'd0;

    // Set/clear collision on x9
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99990001;
    exp_push(5'd9, 32'h99990001);
    tick();
    ld_valid = 1'b0;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9;   // same cycle as the x9 writeback
    tick();
    issue_valid = 1'b0;
    read_index2 = 5'd9;
    @(negedge clk);
    chk("collision_busy", {31'd0, stall}, 32'd1);
    tick();
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99990002;
    exp_push(5'd9, 32'h99990002);
    tick();
    ld_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("collision_cleared", {31'd0, stall}, 32'd0);
    tick();
    read_index2 = 5'd0;

    // Mid-stream reset with a full FIFO and a busy register
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'hE0000001;
    ld_valid = 1'b1; ld_rd = 5'd15; ld_data = 32'hD0000001;
    issue_valid = 1'b1; issue_rd = 5'd4;
    exp_push(5'd14, 32'hE0000001);
    tick();
    alu_data = 32'hE0000002;
    ld_rd = 5'd16; ld_data = 32'hD0000002;
    issue_valid = 1'b0;
    exp_push(5'd14, 32'hE0000002);
    tick();
    alu_rd = 5'd17; alu_data = 32'hE0000003;   // its write is cut by reset
    ld_valid = 1'b0;
    read_index1 = 5'd4;
    @(negedge clk);
    chk("pre_rst_full", {31'd0, ld_ready}, 32'd0);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    tick();
    nRST = 1'b0;
    alu_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("mid_rst_write_data", write_data, 32'd0);
    chk("mid_rst_write_index", {27'd0, write_index}, 32'd0);
    chk("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    tick();
    nRST = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    read_index1 = 5'd0;
    tick();

    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side driver for the 32×32 integer register file, owning its reg_write / write_index / write_data port. It merges single-cycle ALU results and handshaked multi-cycle load results into one registered write per cycle, buffering loads in a small FIFO. It also keeps a per-register busy scoreboard so decode can stall reads of registers with loads in flight. Optionally, it forwards the write being presented to the read ports.

## Interface
- FIFO_DEPTH, 2: load-result buffer entries; power of two, ≥2.
- clk  in  1  clock; all state updates on posedge.
- nRST  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle; no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  buffer can accept; equals FIFO not full.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data.
- issue_valid  in  1  a load is issued this cycle.
- issue_rd  in  5  destination of the issued load.
- read_index1, read_index2  in  5 each  decode source registers.
- stall  out  1  a source register is busy.
- reg_write  out  1  register file write enable; registered.
- write_index  out  5  register file write address; registered.
- write_data  out  32  register file write data; registered.
- fwd_valid1, fwd_valid2  out  1 each  bypass hit per read port.
- fwd_data1, fwd_data2  out  32 each  bypass data per read port.

## Operation
- Per-cycle selection (cycle N):
  - If alu_valid is high, the ALU result is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped.
  - Otherwise nothing is selected.
- Registered write (edge ending cycle N):
  - reg_write <= selected and rd ≠ 0.
  - write_index and write_data <= selected values.
  - When nothing is selected, reg_write <= 0 and write_index/write_data hold.
- x0 handling:
  - A selected entry with rd = 0 is consumed (a FIFO pop still happens) but produces reg_write = 0.
  - issue_rd = 0 never sets a busy bit.
- FIFO:
  - Push when ld_valid && ld_ready.
  - Push and pop in the same cycle are allowed when non-empty; occupancy is unchanged.
  - A push into an empty FIFO is not popped in the same cycle; the earliest pop is the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- Scoreboard: busy[31:1], with busy[0] always 0.
  - Set at an edge when issue_valid is high.
  - Cleared at the edge where reg_write is high, write_index = r, and the write came from the FIFO path.
  - If set and clear for the same register coincide, set wins.
  - ALU writes never clear busy bits.
- stall = (busy[read_index1] && read_index1 ≠ 0) || (busy[read_index2] && read_index2 ≠ 0), subject to the bypass rules under Configuration.
- ALU starvation of loads is allowed. Load producers observe ld_ready = 0 when the FIFO is full.

## Timing
- Reset values while nRST is low:
  - reg_write = 0, write_index = 0, write_data = 0.
  - FIFO empty, so ld_ready = 1.
  - All busy bits = 0, stall = 0.
  - fwd_valid1/2 = 0, fwd_data1/2 = 0.
- Reset mid-operation discards FIFO contents and busy bits immediately (asynchronous).
- ALU latency: alu_valid in cycle N gives reg_write high in cycle N+1. The register file holds the value from cycle N+2.
- Load latency with an empty FIFO and no ALU traffic:
  - Accepted in cycle N, popped in N+1, reg_write high in N+2.
  - The busy bit clears at the end of N+2.
- ld_ready is combinational from FIFO count only; it does not depend on a same-cycle pop.

## Configuration
- WB_BYPASS_EN defined:
  - fwd_validK = reg_write && write_index == read_indexK (read_indexK ≠ 0).
  - fwd_dataK = write_data.
  - stall ignores a busy bit whose register is being written from the FIFO path this cycle.
- WB_BYPASS_EN undefined:
  - fwd_valid1/2 and fwd_data1/2 are tied to 0.
  - stall is additionally asserted when reg_write && write_index == read_indexK ≠ 0, covering both paths.

## Test plan
- Reset: assert nRST low mid-stream -> reg_write = 0, write_data = 0, ld_ready = 1, stall = 0, FIFO drained.
- ALU path: alu_valid, rd = 5, data = 0x12345678 in cycle 1 -> cycle 2 shows reg_write = 1, write_index = 5, write_data = 0x12345678.
- x0 drop: ALU write to rd = 0 and load to rd = 0 -> reg_write stays 0 and the FIFO still pops.
- Priority and full: FIFO_DEPTH = 2 with alu_valid held high for 4 cycles, offering 3 loads -> ld_ready = 0 after 2 pushes. Loads write in order after alu_valid falls.
- Scoreboard:
  - Issue load rd = 7; read_index1 = 7 -> stall = 1.
  - Load data 0xCAFEF00D is written back -> busy clears.
  - With WB_BYPASS_EN: fwd_valid1 = 1 and stall = 0 in the write cycle.
  - Without WB_BYPASS_EN: stall = 1 through the write cycle and 0 afterward.
- Set/clear collision: issue_valid with rd = 9 in the same cycle as the writeback of an older load to rd 9 -> busy[9] remains 1.
